// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU stage sequencer: state encoding, opcode
// constants and opcode classification helpers.
package cpu_ctrl_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_HALT  = 6'h3F;

  function automatic logic is_mem(input logic [OPC_W-1:0] opc);
    return (opc == OP_LW) || (opc == OP_SW);
  endfunction

  function automatic logic is_wb(input logic [OPC_W-1:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_LW);
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_LW) || (opc == OP_SW) ||
           (opc == OP_BEQ) || (opc == OP_HALT);
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer and the datapath stages.
// mem_req is held high until mem_ack is sampled high; mem_ack outside MEM is ignored.
interface stage_sequencer_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic [OP_W-1:0]  op;
  logic             mem_ack;
  logic             fetch_en;
  logic             decode_en;
  logic             alu_en;
  logic             mem_req;
  logic             mem_we;
  logic             wb_en;
  logic             pc_en;
  logic [2:0]       state;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport ctrl (
    input  run, step, op, mem_ack,
    output fetch_en, decode_en, alu_en, mem_req, mem_we, wb_en, pc_en,
           state, busy, halted, err, instr_cnt, cycle_cnt
  );

  modport dp (
    output run, step, op, mem_ack,
    input  fetch_en, decode_en, alu_en, mem_req, mem_we, wb_en, pc_en,
           state, busy, halted, err, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle CPU control: walks IF/ID/EX/MEM/WB one stage per clock and
// produces Moore stage enables, memory handshake, halt/error and counters.
module stage_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  stage_sequencer_if.ctrl bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic              step_mode_q, step_mode_d;
  logic              err_q, err_d;
  logic              retire;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  instr_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              busy;

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    err_d       = err_q;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d     = S_IF;
          step_mode_d = 1'b0;
        end else if (bus.step) begin
          state_d     = S_IF;
          step_mode_d = 1'b1;
        end
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        if (bus.op == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (!is_legal(bus.op)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: state_d = is_mem(op_q) ? S_MEM : S_WB;
      S_MEM: begin
        // wait_q is 0 in the first MEM cycle, so an ack in cycle MEM_TIMEOUT still wins
        if (bus.mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB: begin
        retire      = 1'b1;
        step_mode_d = 1'b0;
        state_d     = (bus.run && !step_mode_q) ? S_IF : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_mode_q <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= '0;
      wait_q      <= '0;
      instr_q     <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      err_q       <= err_d;
      if (state_q == S_ID) op_q <= bus.op;
      wait_q      <= (state_q == S_MEM) ? wait_q + 1'b1 : '0;
      if (retire) instr_q <= instr_q + 1'b1;
      if (busy)   cycle_q <= cycle_q + 1'b1;
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);

  assign bus.fetch_en  = (state_q == S_IF);
  assign bus.decode_en = (state_q == S_ID);
  assign bus.alu_en    = (state_q == S_EX);
  assign bus.mem_req   = (state_q == S_MEM);
  assign bus.mem_we    = (state_q == S_MEM) && (op_q == OP_SW);
  assign bus.wb_en     = (state_q == S_WB) && is_wb(op_q);
  assign bus.pc_en     = (state_q == S_WB);
  assign bus.state     = state_q;
  assign bus.busy      = busy;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.err       = err_q;
  assign bus.instr_cnt = instr_q;
  assign bus.cycle_cnt = cycle_q;

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control unit that sequences the CPU datapath (fetch, decode, alu, v_memory, write) one stage per clock. It replaces free-running stage activity with per-stage enables, a memory request/acknowledge handshake with timeout, and run/single-step/halt control. It sits at CPU top level: stage blocks consume its enables, and the decode opcode feeds back into it.

## Interface
Parameters:
- OP_W, 6, opcode width
- CNT_W, 32, width of instruction and cycle counters
- MEM_TIMEOUT, 15, max MEM-state cycles without mem_ack before error

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = execute continuously
- step  in  1  one-cycle pulse; from IDLE, execute exactly one instruction
- op  in  OP_W  opcode from decode, valid in ID
- mem_ack  in  1  memory completion; ignored outside MEM
- fetch_en / decode_en / alu_en  out  1  stage enables
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write qualifier (store)
- wb_en  out  1  register-file update enable
- pc_en  out  1  PC update enable, one pulse per instruction
- state  out  3  current state encoding
- busy  out  1  state not IDLE and not HALT
- halted  out  1  state == HALT
- err  out  1  sticky error (timeout or illegal opcode)
- instr_cnt  out  CNT_W  retired instructions
- cycle_cnt  out  CNT_W  busy cycles

## Operation
- States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. Outputs are Moore decodes of state and latched op_q.
- IDLE: run=1 -> IF (continuous); else step=1 -> IF with step_mode=1. Both high: run wins, step_mode=0.
- IF: fetch_en=1 -> ID.
- ID: decode_en=1; op latched into op_q. HALT opcode (6'h3F) -> HALT, retires (instr_cnt+1). Opcode outside {6'h00 R-type, 6'h23 load, 6'h2B store, 6'h04 beq, 6'h3F halt} -> HALT, err=1, no retire. Otherwise -> EX.
- EX: alu_en=1 -> MEM for load/store, else -> WB.
- MEM: mem_req=1, mem_we=1 only for store. Stay until mem_ack=1 -> WB. Wait counter counts MEM cycles; if MEM_TIMEOUT cycles elapse with no ack -> HALT, err=1. Ack in the final allowed cycle is accepted.
- WB: pc_en=1; wb_en=1 for R-type and load only. Retire: instr_cnt+1. Next: run=1 and step_mode=0 -> IF, else IDLE (step_mode cleared).
- HALT: absorbing until reset; run/step ignored.
- run dropping mid-instruction: instruction completes, then IDLE. step while not IDLE ignored.
- cycle_cnt increments every cycle busy=1. Both counters wrap modulo 2^CNT_W.

## Timing
- Reset (async, rst=0): state=IDLE, all enables 0, busy=0, halted=0, err=0, counters 0, op_q=0, step_mode=0. Reset mid-instruction aborts immediately; no enable pulses after assertion.
- Latency: R-type/beq 4 cycles (IF,ID,EX,WB); load/store 5 + (ack wait - 1) cycles.
- IDLE -> IF one cycle after run/step sampled high.
- mem_req rises on MEM entry, falls on the edge ack is sampled; exactly one WB follows.
- Back-to-back: WB followed directly by IF, no bubble.

## Structure
- Package cpu_ctrl_pkg: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_HALT), op-class functions (is_mem, is_wb, is_legal).
- Single module; wait counter and both counters inline, no sub-module.

## Test plan
- Reset, run=1, op=6'h00 held: states 1,2,3,5, then IF; after 4 busy cycles instr_cnt=1, cycle_cnt=4, wb_en and pc_en each one pulse.
- Load 6'h23, mem_ack on 3rd MEM cycle: mem_req high 3 cycles, mem_we=0, wb_en=1 in WB, instruction takes 7 cycles.
- Store 6'h2B, ack in 1st MEM cycle: mem_we=1 for 1 cycle, WB with wb_en=0, pc_en=1.
- run=0, step pulse with op=6'h04: one instruction then IDLE, instr_cnt=1; second step -> instr_cnt=2.
- Load with no ack: after 15 MEM cycles state=6, err=1, halted=1; run=1 has no effect; rst=0 clears all.
- op=6'h15 in ID -> HALT, err=1, instr_cnt unchanged; op=6'h3F -> HALT, err=0, instr_cnt+1; rst asserted during MEM -> IDLE, mem_req=0 immediately.
